// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing defaults, shared types and colour-bar lookup
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam bit SYNC_ACTIVE = 1'b0;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb888_t bar_rgb(input logic [2:0] idx);
    rgb888_t c;
    case (idx)
      3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
      3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
      3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
      3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
      3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
      default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pixel-coordinate request / colour return between timing gen and frame source
interface vga_if;
  import vga_pkg::*;

  logic       req_valid;
  coord_t     req_x;
  coord_t     req_y;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;

  modport master (output req_valid, req_x, req_y, input pix_r, pix_g, pix_b);
  modport slave  (input req_valid, req_x, req_y, output pix_r, pix_g, pix_b);

endinterface

// File: rtl/vga_lock_sync.sv
// rtl/vga_lock_sync.sv - 2-FF synchroniser bringing the PLL lock flag into the pixel clock domain
module vga_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/blank generator with coordinate requests and 3-stage colour alignment
// Optional build macro: VGA_TEST_PATTERN_EN replaces the upstream colour with 8 vertical bars.
module vga_timing_gen #(
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int H_FP        = vga_pkg::H_FP,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_BP        = vga_pkg::H_BP,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int V_FP        = vga_pkg::V_FP,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_BP        = vga_pkg::V_BP,
  parameter bit SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  vga_if.master      bus,
  output logic       frame_start,
  output logic       line_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);
  import vga_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
  localparam coord_t H_HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic    lk_s;
  logic    hold;
  coord_t  h_cnt, v_cnt;
  logic    hs0, vs0;
  logic    hs1, vs1, v1;
  rgb888_t pix_out;

  vga_lock_sync u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pll_locked),
    .sync_out (lk_s)
  );

  assign hold = rst | ~lk_s;

  always_ff @(posedge clk) begin
    if (hold) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Stage 0: decode the counters into request, start pulses and raw syncs
  always_ff @(posedge clk) begin
    if (hold) begin
      bus.req_valid <= 1'b0;
      bus.req_x     <= '0;
      bus.req_y     <= '0;
      frame_start   <= 1'b0;
      line_start    <= 1'b0;
      hs0           <= 1'b0;
      vs0           <= 1'b0;
    end else begin
      bus.req_valid <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      bus.req_x     <= ((h_cnt < H_VIS) && (v_cnt < V_VIS)) ? h_cnt : '0;
      bus.req_y     <= ((h_cnt < H_VIS) && (v_cnt < V_VIS)) ? v_cnt : '0;
      frame_start   <= (h_cnt == '0) && (v_cnt == '0);
      line_start    <= (h_cnt == '0);
      hs0           <= (h_cnt >= H_HS_START) && (h_cnt < H_HS_END);
      vs0           <= (v_cnt >= V_VS_START) && (v_cnt < V_VS_END);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  coord_t x1;

  always_ff @(posedge clk) begin
    if (hold) x1 <= '0;
    else      x1 <= bus.req_x;
  end
`endif

  // Stage 1: wait out the source's one-clock latency so syncs line up with pix_*
  always_ff @(posedge clk) begin
    if (hold) begin
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      v1  <= 1'b0;
    end else begin
      hs1 <= hs0;
      vs1 <= vs0;
      v1  <= bus.req_valid;
    end
  end

  always_comb begin
    pix_out = '0;
    if (v1) begin
`ifdef VGA_TEST_PATTERN_EN
      pix_out = bar_rgb(3'(x1 / 10'd80));
`else
      pix_out = '{r: bus.pix_r, g: bus.pix_g, b: bus.pix_b};
`endif
    end
  end

  // Stage 2: registered DAC-facing outputs
  always_ff @(posedge clk) begin
    if (hold) begin
      vga_hs      <= ~SYNC_ACTIVE;
      vga_vs      <= ~SYNC_ACTIVE;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= hs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vga_vs      <= vs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vga_blank_n <= v1;
      vga_r       <= pix_out.r;
      vga_g       <= pix_out.g;
      vga_b       <= pix_out.b;
    end
  end

endmodule
